// File: rtl/au_pkg.sv
// Shared types and sizing for the arithmetic-unit sequencer.
// Holds the opcode and FSM state encodings plus the datapath width and iteration count.
package au_pkg;

  localparam int AU_W    = 32;
  localparam int AU_ITER = 32;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MULT = 2'b10,
    OP_DIV  = 2'b11
  } au_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } au_state_e;

endpackage

// File: rtl/au_rr_arbiter.sv
// Two-way round-robin arbiter: grant is combinational and gated by en,
// the last-granted index is remembered so a tie goes to the other requester.
module au_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic       en,
  output logic [1:0] grant
);

  logic last_q, last_d;
  logic [1:0] raw;

  always_comb begin
    raw = req_valid;
    if (req_valid == 2'b11) raw = last_q ? 2'b01 : 2'b10;
    grant  = en ? raw : 2'b00;
    last_d = last_q;
    if (grant != 2'b00) last_d = grant[1];
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/au_sequencer.sv
// Arithmetic-unit sequencer: arbitrates two requesters, runs ADD/SUB in one cycle and
// unsigned MULT/DIV iteratively, then holds the response until the consumer takes it.
//
// state   | meaning
// IDLE    | waiting for a granted request; req_ready follows the arbiter
// EXEC    | operands captured; one cycle for ADD/SUB/short-circuits, 32 for MULT/DIV
// DONE    | response presented and held until rsp_valid & rsp_ready
module au_sequencer
  import au_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [1:0]  req_op0,
  input  logic [1:0]  req_op1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] s,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        zero,
  output logic        err
);

  localparam logic [4:0] CNT_LAST = 5'(AU_ITER - 1);

  au_state_e       state_q, state_d;
  au_op_e          op_q, op_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [AU_W-1:0] a_q, a_d, b_q, b_d, wh_q, wh_d, wl_q, wl_d;
  logic [AU_W-1:0] s_q, s_d, hi_q, hi_d, lo_q, lo_d;
  logic            id_q, id_d, rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic            zero_q, zero_d, err_q, err_d;

  logic [1:0]      grant;
  logic            sel_id;
  logic [AU_W-1:0] sel_a, sel_b, addsub;
  au_op_e          sel_op;
  logic [AU_W:0]   mul_sum, div_shift;
  logic [AU_W-1:0] mul_hi, mul_lo, div_hi, div_lo, div_sub;
  logic            div_ge;

  au_rr_arbiter u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .en        ((state_q == ST_IDLE) && !rst),
    .grant     (grant)
  );

  assign req_ready = grant;
  assign sel_id    = grant[1];
  assign sel_a     = sel_id ? req_a1 : req_a0;
  assign sel_b     = sel_id ? req_b1 : req_b0;
  assign sel_op    = sel_id ? au_op_e'(req_op1) : au_op_e'(req_op0);

  // Shift-add step: {wh,wl} shifts right with the carry out of the partial sum.
  assign mul_sum = {1'b0, wh_q} + (wl_q[0] ? {1'b0, a_q} : '0);
  assign mul_hi  = mul_sum[AU_W:1];
  assign mul_lo  = {mul_sum[0], wl_q[AU_W-1:1]};

  // Restoring step: remainder in wh, dividend shifts out of wl as quotient bits shift in.
  assign div_shift = {wh_q, wl_q[AU_W-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign div_sub   = div_shift[AU_W-1:0] - b_q;
  assign div_hi    = div_ge ? div_sub : div_shift[AU_W-1:0];
  assign div_lo    = {wl_q[AU_W-2:0], div_ge};

  assign addsub = (op_q == OP_SUB) ? (a_q + ~b_q + 32'd1) : (a_q + b_q);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    wh_d        = wh_q;
    wl_d        = wl_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    s_d         = s_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    zero_d      = zero_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          a_d     = sel_a;
          b_d     = sel_b;
          op_d    = sel_op;
          id_d    = sel_id;
          wh_d    = '0;
          wl_d    = (sel_op == OP_DIV) ? sel_a : sel_b;
          cnt_d   = '0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_ADD, OP_SUB: begin
            state_d = ST_DONE;
            s_d     = addsub;
            hi_d    = '0;
            lo_d    = '0;
            zero_d  = (addsub == '0);
            err_d   = 1'b0;
          end
          OP_MULT: begin
            if (a_q == '0 || b_q == '0) begin
              state_d = ST_DONE;
              s_d     = '0;
              hi_d    = '0;
              lo_d    = '0;
              zero_d  = 1'b1;
              err_d   = 1'b0;
            end else begin
              wh_d  = mul_hi;
              wl_d  = mul_lo;
              cnt_d = cnt_q + 5'd1;
              if (cnt_q == CNT_LAST) begin
                state_d = ST_DONE;
                s_d     = '0;
                hi_d    = mul_hi;
                lo_d    = mul_lo;
                zero_d  = ({mul_hi, mul_lo} == '0);
                err_d   = 1'b0;
              end
            end
          end
          default: begin
            if (b_q == '0) begin
              state_d = ST_DONE;
              s_d     = '0;
              hi_d    = a_q;
              lo_d    = '1;
              zero_d  = 1'b0;
              err_d   = 1'b1;
            end else begin
              wh_d  = div_hi;
              wl_d  = div_lo;
              cnt_d = cnt_q + 5'd1;
              if (cnt_q == CNT_LAST) begin
                state_d = ST_DONE;
                s_d     = '0;
                hi_d    = div_hi;
                lo_d    = div_lo;
                zero_d  = (div_lo == '0);
                err_d   = 1'b0;
              end
            end
          end
        endcase
        if (state_d == ST_DONE) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      wh_q        <= '0;
      wl_q        <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      s_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      wh_q        <= wh_d;
      wl_q        <= wl_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      s_q         <= s_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign s         = s_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule
